// File: rtl/smpl_queue_if.sv
// smpl_queue_if: sample write and readout signals of the circular sample queue
interface smpl_queue_if;
  logic wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
  logic ovr;
  modport master (output wrt_smpl, lft_smpl, rght_smpl, input sequencing, lft_out, rght_out, ovr);
  modport slave (input wrt_smpl, lft_smpl, rght_smpl, output sequencing, lft_out, rght_out, ovr);
endinterface

// File: rtl/smpl_queue.sv
// smpl_queue: circular stereo sample queue with oldest-first readout of the last NUM_TAPS samples
module smpl_queue #(
  parameter int DEPTH = 1536,
  parameter int NUM_TAPS = 1021
) (
  input logic clk,
  input logic rst,
  smpl_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_TAPS + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] TAPS = CW'(NUM_TAPS);
  localparam logic [CW-1:0] LAST_TAP = CW'(NUM_TAPS - 1);
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);
  localparam logic [PW:0] BACK = (PW + 1)'(DEPTH - NUM_TAPS);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [PW-1:0] new_ptr, rd_ptr, new_ptr_nxt, start_ptr;
  logic [PW:0] back_sum;
  logic [CW-1:0] cnt, cnt_nxt, tap_cnt;
  logic acc;
  // accepted write, next pointer/count, and readout start address (new_ptr_nxt - NUM_TAPS mod DEPTH)
  always_comb begin
    acc = q.wrt_smpl && state == IDLE;
    new_ptr_nxt = new_ptr == PTR_MAX ? '0 : new_ptr + PW'(1);
    cnt_nxt = cnt == TAPS ? cnt : cnt + CW'(1);
    back_sum = {1'b0, new_ptr_nxt} + BACK;
    start_ptr = back_sum >= DEPTH_W ? PW'(back_sum - DEPTH_W) : PW'(back_sum);
  end
  // sample storage, deliberately not reset
  always_ff @(posedge clk)
    if (acc) mem[new_ptr] <= {q.lft_smpl, q.rght_smpl};
  // queue control: fill, trigger readout, sequence NUM_TAPS reads, drain the last read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      new_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      tap_cnt <= '0;
      q.sequencing <= 1'b0;
      q.ovr <= 1'b0;
      q.lft_out <= '0;
      q.rght_out <= '0;
    end else begin
      q.ovr <= q.wrt_smpl && state != IDLE;
      case (state)
        IDLE: if (acc) begin
          new_ptr <= new_ptr_nxt;
          cnt <= cnt_nxt;
          if (cnt_nxt == TAPS) begin
            state <= READ;
            rd_ptr <= start_ptr;
            tap_cnt <= '0;
            q.sequencing <= 1'b1;
          end
        end
        READ: begin
          {q.lft_out, q.rght_out} <= mem[rd_ptr];
          rd_ptr <= rd_ptr == PTR_MAX ? '0 : rd_ptr + PW'(1);
          tap_cnt <= tap_cnt + CW'(1);
          if (tap_cnt == LAST_TAP) state <= DRAIN;
        end
        default: begin
          state <= IDLE;
          q.sequencing <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_smpl_queue.sv
// tb_smpl_queue: directed vectors for a small (8/5) queue and the default-size queue
module tb_smpl_queue;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;
  smpl_queue_if qa();
  smpl_queue_if qb();
  smpl_queue #(.DEPTH(8), .NUM_TAPS(5)) dut_a (.clk(clk), .rst(rst_a), .q(qa));
  smpl_queue dut_b (.clk(clk), .rst(rst_b), .q(qb));
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic [15:0] lft;
    logic trig;
    logic [0:4][15:0] exp;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_seq"}, {15'd0, qa.sequencing}, 16'd0);
    chk({tag, "_ovr"}, {15'd0, qa.ovr}, 16'd0);
    chk({tag, "_lft"}, qa.lft_out, 16'd0);
    chk({tag, "_rght"}, qa.rght_out, 16'd0);
  endtask
  task automatic write_a(input logic [15:0] v, input logic trig, input logic [0:4][15:0] exp, input bit inj);
    @(negedge clk);
    qa.wrt_smpl = 1'b1;
    qa.lft_smpl = v;
    qa.rght_smpl = -v;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      qa.wrt_smpl = inj && j == 3;
      qa.lft_smpl = 16'd99;
      qa.rght_smpl = -16'sd99;
      chk($sformatf("a_seq w%0d c%0d", v, j), {15'd0, qa.sequencing}, {15'd0, trig && j <= 6});
      chk($sformatf("a_ovr w%0d c%0d", v, j), {15'd0, qa.ovr}, {15'd0, inj && j == 4});
      if (trig && j >= 2 && j <= 6) begin
        chk($sformatf("a_lft w%0d k%0d", v, j - 2), qa.lft_out, exp[j-2]);
        chk($sformatf("a_rght w%0d k%0d", v, j - 2), qa.rght_out, -exp[j-2]);
      end
    end
  endtask
  task automatic write_b(input logic [15:0] v);
    @(negedge clk);
    qb.wrt_smpl = 1'b1;
    qb.lft_smpl = v;
    qb.rght_smpl = -v;
    @(negedge clk);
    qb.wrt_smpl = 1'b0;
  endtask
  task automatic readout_b(input logic [15:0] v, input logic [15:0] first);
    int n;
    bit bad;
    logic [15:0] e, ne;
    n = 0;
    bad = 1'b0;
    write_b(v);
    if (qb.sequencing) n++;
    for (int j = 2; j <= 1030; j++) begin
      @(negedge clk);
      if (qb.sequencing) n++;
      e = 16'(first + j - 2);
      ne = -e;
      if (j <= 1022 && (qb.lft_out !== e || qb.rght_out !== ne)) bad = 1'b1;
    end
    chk($sformatf("b_seq_len w%0d", v), 16'(n), 16'd1022);
    chk($sformatf("b_data w%0d", v), {15'd0, bad}, 16'd0);
  endtask
  initial begin
    bit fill_bad;
    tbl[0]  = {16'd1,  1'b0, 80'd0};
    tbl[1]  = {16'd2,  1'b0, 80'd0};
    tbl[2]  = {16'd3,  1'b0, 80'd0};
    tbl[3]  = {16'd4,  1'b0, 80'd0};
    tbl[4]  = {16'd5,  1'b1, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
    tbl[5]  = {16'd6,  1'b1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    tbl[6]  = {16'd7,  1'b1, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
    tbl[7]  = {16'd8,  1'b1, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[8]  = {16'd9,  1'b1, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    tbl[9]  = {16'd10, 1'b1, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10};
    tbl[10] = {16'd11, 1'b1, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11};
    rst_a = 1'b1;
    rst_b = 1'b1;
    qa.wrt_smpl = 1'b0;
    qa.lft_smpl = '0;
    qa.rght_smpl = '0;
    qb.wrt_smpl = 1'b0;
    qb.lft_smpl = '0;
    qb.rght_smpl = '0;
    repeat (2) @(negedge clk);
    chk_reset("a_rst");
    chk("b_rst_seq", {15'd0, qb.sequencing}, 16'd0);
    chk("b_rst_ovr", {15'd0, qb.ovr}, 16'd0);
    chk("b_rst_lft", qb.lft_out, 16'd0);
    chk("b_rst_rght", qb.rght_out, 16'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int i = 0; i < 11; i++) write_a(tbl[i].lft, tbl[i].trig, tbl[i].exp, 1'b0);
    write_a(16'd12, 1'b1, {16'd8, 16'd9, 16'd10, 16'd11, 16'd12}, 1'b1);
    write_a(16'd13, 1'b1, {16'd9, 16'd10, 16'd11, 16'd12, 16'd13}, 1'b0);
    @(negedge clk);
    qa.wrt_smpl = 1'b1;
    qa.lft_smpl = 16'd14;
    qa.rght_smpl = -16'sd14;
    @(negedge clk);
    qa.wrt_smpl = 1'b0;
    repeat (2) @(negedge clk);
    chk("a_seq_pre_rst", {15'd0, qa.sequencing}, 16'd1);
    chk("a_lft_pre_rst", qa.lft_out, 16'd11);
    rst_a = 1'b1;
    #1;
    chk_reset("a_midrst");
    repeat (3) @(negedge clk);
    chk_reset("a_midrst_hold");
    rst_a = 1'b0;
    for (int v = 1; v <= 4; v++) write_a(16'(v), 1'b0, '0, 1'b0);
    write_a(16'd5, 1'b1, {16'd1, 16'd2, 16'd3, 16'd4, 16'd5}, 1'b0);
    fill_bad = 1'b0;
    for (int v = 1; v <= 1020; v++) begin
      write_b(16'(v));
      if (qb.sequencing !== 1'b0) fill_bad = 1'b1;
    end
    chk("b_fill_no_seq", {15'd0, fill_bad}, 16'd0);
    readout_b(16'd1021, 16'd1);
    readout_b(16'd1022, 16'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
